// File: rtl/mire_pattern_gen.sv
// Wishbone write master that fills a framebuffer with an RGB565 test pattern
// (grid, colour bars, checkerboard or solid), frame after frame, in bursts with idle gaps.
module mire_pattern_gen #(
    parameter int unsigned     HDISP     = 640,
    parameter int unsigned     VDISP     = 480,
    parameter int unsigned     GRID      = 16,
    parameter longint unsigned BASE_ADR  = 0,
    parameter int unsigned     ADR_W     = 32,
    parameter int unsigned     BURST_LEN = 64,
    parameter int unsigned     GAP_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [15:0]      solid_color,
    output logic             frame_done,
    output logic             busy,
    output logic [ADR_W-1:0] wb_adr,
    output logic [15:0]      wb_dat_ms,
    output logic [1:0]       wb_sel,
    output logic             wb_we,
    output logic [2:0]       wb_cti,
    output logic [1:0]       wb_bte,
    output logic             wb_stb,
    output logic             wb_cyc,
    input  logic             wb_ack
);

    localparam int XW   = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int YW   = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int LG   = $clog2(GRID);
    localparam int BARW = (HDISP / 8 > 0) ? HDISP / 8 : 1;
    localparam int BCW  = $clog2(BARW + 1);
    localparam int BLW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GLW  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [ADR_W-1:0] BASE = ADR_W'(BASE_ADR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [BLW-1:0]   bcnt_q, bcnt_d;
    logic [GLW-1:0]   gcnt_q, gcnt_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [2:0]       bar_q, bar_d;
    logic [BCW-1:0]   barcnt_q, barcnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [15:0]      solid_q, solid_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [15:0]      dat_q, dat_d;
    logic             init_q, init_d;
    logic             fd_q, fd_d;
    logic             ack_fire;
    logic             last_x, last_y;

    function automatic logic [15:0] pattern_px(input logic [1:0] m, input logic [15:0] solid,
                                               input logic [XW-1:0] px, input logic [YW-1:0] py,
                                               input logic [2:0] bar);
        logic [15:0] c;
        c = 16'h0000;
        case (m)
            2'd0: begin
                if (((32'(px) & (GRID - 1)) == 0) || ((32'(py) & (GRID - 1)) == 0))
                    c = 16'hFFFF;
            end
            2'd1: begin
                case (bar)
                    3'd0:    c = 16'hFFFF;
                    3'd1:    c = 16'hFFE0;
                    3'd2:    c = 16'h07FF;
                    3'd3:    c = 16'h07E0;
                    3'd4:    c = 16'hF81F;
                    3'd5:    c = 16'hF800;
                    3'd6:    c = 16'h001F;
                    default: c = 16'h0000;
                endcase
            end
            2'd2: begin
                if ((((32'(px) >> LG) ^ (32'(py) >> LG)) & 32'd1) != 0)
                    c = 16'hFFFF;
            end
            default: c = solid;
        endcase
        return c;
    endfunction

    assign ack_fire = (state_q == S_BURST) && wb_ack;
    assign last_x   = (x_q == XW'(HDISP - 1));
    assign last_y   = (y_q == YW'(VDISP - 1));

    // Burst/gap sequencing; a pending request is only released by its ack.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            S_IDLE: begin
                bcnt_d = '0;
                gcnt_d = '0;
                if (enable)
                    state_d = S_BURST;
            end
            S_BURST: begin
                gcnt_d = '0;
                if (ack_fire) begin
                    if (!enable) begin
                        state_d = S_IDLE;
                        bcnt_d  = '0;
                    end else if (bcnt_q == BLW'(BURST_LEN - 1)) begin
                        state_d = S_GAP;
                        bcnt_d  = '0;
                    end else begin
                        bcnt_d = bcnt_q + BLW'(1);
                    end
                end
            end
            S_GAP: begin
                bcnt_d = '0;
                if (gcnt_q == GLW'(GAP_LEN - 1)) begin
                    gcnt_d  = '0;
                    state_d = enable ? S_BURST : S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + GLW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pixel walker: address and data are prepared for the next pixel on each ack.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        bar_d    = bar_q;
        barcnt_d = barcnt_q;
        mode_d   = mode_q;
        solid_d  = solid_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        init_d   = init_q;
        fd_d     = 1'b0;
        if (init_q) begin
            init_d   = 1'b0;
            mode_d   = mode;
            solid_d  = solid_color;
            x_d      = '0;
            y_d      = '0;
            bar_d    = '0;
            barcnt_d = '0;
            adr_d    = BASE;
            dat_d    = pattern_px(mode, solid_color, '0, '0, 3'd0);
        end else if (ack_fire) begin
            fd_d = last_x && last_y;
            if (last_x) begin
                x_d      = '0;
                bar_d    = '0;
                barcnt_d = '0;
                y_d      = last_y ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
                if (bar_q != 3'd7) begin
                    if (barcnt_q == BCW'(BARW - 1)) begin
                        bar_d    = bar_q + 3'd1;
                        barcnt_d = '0;
                    end else begin
                        barcnt_d = barcnt_q + BCW'(1);
                    end
                end
            end
            if (last_x && last_y) begin
                adr_d   = BASE;
                mode_d  = mode;
                solid_d = solid_color;
            end else begin
                adr_d = adr_q + ADR_W'(2);
            end
            dat_d = pattern_px(mode_d, solid_d, x_d, y_d, bar_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            gcnt_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            bar_q    <= '0;
            barcnt_q <= '0;
            mode_q   <= '0;
            solid_q  <= '0;
            adr_q    <= BASE;
            dat_q    <= '0;
            init_q   <= 1'b1;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            gcnt_q   <= gcnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            bar_q    <= bar_d;
            barcnt_q <= barcnt_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            init_q   <= init_d;
            fd_q     <= fd_d;
        end
    end

    assign wb_adr     = adr_q;
    assign wb_dat_ms  = dat_q;
    assign wb_stb     = (state_q == S_BURST);
    assign wb_cyc     = (state_q == S_BURST);
    assign wb_sel     = 2'b11;
    assign wb_we      = 1'b1;
    assign wb_cti     = 3'b000;
    assign wb_bte     = 2'b00;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = fd_q;

endmodule

// File: tb/tb_mire_pattern_gen.sv
// Directed bench for mire_pattern_gen: a reference pixel model pushes expected writes to a
// scoreboard queue as acks are driven, and each completed write is popped and compared.
module tb_mire_pattern_gen;

    localparam int H  = 640;
    localparam int V  = 18;
    localparam int G  = 16;
    localparam int BL = 64;
    localparam int GL = 4;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [15:0] solid_color;
    logic        frame_done, busy;
    logic [31:0] wb_adr;
    logic [15:0] wb_dat_ms;
    logic [1:0]  wb_sel, wb_bte;
    logic        wb_we, wb_stb, wb_cyc;
    logic [2:0]  wb_cti;
    logic        wb_ack = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;

    exp_t        sb[$];
    exp_t        e;
    int          mx, my, rmode, stop_x, stop_y, ack_mode, fd_cnt;
    int          hi_run, lo_run, dly, wcnt;
    logic [15:0] rsolid;
    logic        need_latch, exp_fd, pend, last_stb, seen_fall, new_txn, chk_runs, a;
    logic [31:0] padr;
    logic [15:0] pdat;

    mire_pattern_gen #(
        .HDISP(H), .VDISP(V), .GRID(G), .BASE_ADR(0), .ADR_W(32),
        .BURST_LEN(BL), .GAP_LEN(GL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .solid_color(solid_color),
        .frame_done(frame_done), .busy(busy), .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms),
        .wb_sel(wb_sel), .wb_we(wb_we), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_stb(wb_stb), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_px(input int m, input logic [15:0] s, input int x, input int y);
        int b;
        case (m)
            0: return ((x % G == 0) || (y % G == 0)) ? 16'hFFFF : 16'h0000;
            1: begin
                b = x / (H / 8);
                if (b > 7) b = 7;
                case (b)
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2: return ((((x / G) ^ (y / G)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            default: return s;
        endcase
    endfunction

    // Slave model, reference walker and scoreboard, all evaluated on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mx = 0; my = 0; need_latch = 1'b1; sb.delete(); wb_ack = 1'b0;
            exp_fd = 1'b0; pend = 1'b0; last_stb = 1'b0; hi_run = 0; lo_run = 0;
            seen_fall = 1'b0; new_txn = 1'b1; wcnt = 0; dly = 0;
        end else begin
            check("frame_done", 32'(frame_done), 32'(exp_fd));
            if (frame_done) fd_cnt++;
            exp_fd = 1'b0;
            if (need_latch) begin
                rmode = int'(mode); rsolid = solid_color; need_latch = 1'b0;
            end
            if (pend && wb_stb) begin
                check("hold_adr", wb_adr, padr);
                check("hold_dat", 32'(wb_dat_ms), 32'(pdat));
            end
            if (wb_stb != last_stb) begin
                if (chk_runs && !wb_stb) check("burst_len", 32'(hi_run), 32'(BL));
                if (chk_runs && wb_stb && seen_fall) check("gap_len", 32'(lo_run), 32'(GL));
                if (!wb_stb) seen_fall = 1'b1;
                hi_run = 0; lo_run = 0;
            end
            if (wb_stb) hi_run++; else lo_run++;
            last_stb = wb_stb;
            case (ack_mode)
                0: a = 1'b1;
                1: begin
                    if (!wb_stb) a = 1'($urandom_range(0, 1));
                    else begin
                        if (new_txn) begin dly = $urandom_range(0, 5); wcnt = 0; new_txn = 1'b0; end
                        a = (wcnt == dly);
                        wcnt++;
                    end
                end
                default: a = !(mx == stop_x && my == stop_y);
            endcase
            wb_ack = a;
            pend = wb_stb && !a; padr = wb_adr; pdat = wb_dat_ms;
            if (wb_stb && a) begin
                e.adr = 32'(2 * (H * my + mx));
                e.dat = ref_px(rmode, rsolid, mx, my);
                sb.push_back(e);
                new_txn = 1'b1;
                e = sb.pop_front();
                check("sb_adr", wb_adr, e.adr);
                check("sb_dat", 32'(wb_dat_ms), 32'(e.dat));
                if (mx == H - 1 && my == V - 1) begin
                    exp_fd = 1'b1; mx = 0; my = 0; rmode = int'(mode); rsolid = solid_color;
                end else if (mx == H - 1) begin
                    mx = 0; my++;
                end else begin
                    mx++;
                end
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk); #2;
    endtask

    task automatic obs_tick();
        @(posedge clk); #4;
    endtask

    task automatic do_reset(input logic [1:0] m);
        drive_tick();
        rst_n = 1'b0; mode = m; enable = 1'b1;
        drive_tick();
        drive_tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_px(input int x, input int y, input int budget);
        int n;
        n = 0;
        do begin obs_tick(); n++; end
        while (!(mx == x && my == y && wb_stb) && n < budget);
        check($sformatf("reach_%0d_%0d", x, y), 32'(mx == x && my == y && wb_stb), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; mode = 2'd0; solid_color = 16'h0;
        ack_mode = 0; chk_runs = 1'b0; stop_x = -1; stop_y = -1; fd_cnt = 0;
        rmode = 0; rsolid = 16'h0;

        // Grid pattern after reset, ack always high.
        chk_runs = 1'b1; enable = 1'b1;
        obs_tick(); obs_tick();
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_adr", wb_adr, 32'd0);
        check("rst_dat", 32'(wb_dat_ms), 32'd0);
        drive_tick();
        rst_n = 1'b1;
        wait_px(0, 0, 20);
        check("g00_adr", wb_adr, 32'h0);
        check("g00_dat", 32'(wb_dat_ms), 32'hFFFF);
        check("g00_const", {wb_sel, wb_we, wb_cti, wb_bte}, 32'b11_1_000_00);
        wait_px(1, 1, 2000);
        check("g11_adr", wb_adr, 32'h502);
        check("g11_dat", 32'(wb_dat_ms), 32'h0000);
        wait_px(16, 1, 200);
        check("g161_dat", 32'(wb_dat_ms), 32'hFFFF);

        // Colour bars, then a mid-frame switch to solid that lands at the next frame.
        do_reset(2'd1);
        wait_px(0, 0, 20);
        check("b00_dat", 32'(wb_dat_ms), 32'hFFFF);
        wait_px(639, 0, 2000);
        check("b6390_adr", wb_adr, 32'h4FE);
        check("b6390_dat", 32'(wb_dat_ms), 32'h0000);
        wait_px(80, 5, 5000);
        check("b805_dat", 32'(wb_dat_ms), 32'hFFE0);
        drive_tick();
        mode = 2'd3; solid_color = 16'h1234;
        wait_px(300, 5, 1000);
        check("b3005_dat", 32'(wb_dat_ms), 32'h07E0);
        fd_cnt = 0;
        begin
            int n;
            n = 0;
            do begin obs_tick(); n++; end while (!frame_done && n < 20000);
            check("fd_seen", 32'(frame_done), 32'd1);
        end
        check("wrap_adr", wb_adr, 32'h0);
        check("wrap_dat", 32'(wb_dat_ms), 32'h1234);
        obs_tick();
        check("fd_pulse", 32'(frame_done), 32'd0);
        wait_px(3, 1, 2000);
        check("s31_dat", 32'(wb_dat_ms), 32'h1234);
        check("fd_count", 32'(fd_cnt), 32'd1);

        // Checkerboard with random ack latency.
        drive_tick();
        chk_runs = 1'b0; ack_mode = 1;
        do_reset(2'd2);
        wait_px(0, 0, 20);
        check("c00_dat", 32'(wb_dat_ms), 32'h0000);
        wait_px(16, 0, 500);
        check("c160_adr", wb_adr, 32'd32);
        check("c160_dat", 32'(wb_dat_ms), 32'hFFFF);
        wait_px(16, 16, 60000);
        check("c1616_adr", wb_adr, 32'h5020);
        check("c1616_dat", 32'(wb_dat_ms), 32'h0000);

        // Drop enable while a write is pending, then resume.
        drive_tick();
        ack_mode = 2; stop_x = 10; stop_y = 3;
        do_reset(2'd0);
        wait_px(10, 3, 5000);
        drive_tick();
        enable = 1'b0;
        obs_tick(); obs_tick(); obs_tick();
        check("hold_stb", 32'(wb_stb), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_adr103", wb_adr, 32'd3860);
        drive_tick();
        ack_mode = 0;
        obs_tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_stb", 32'(wb_stb), 32'd0);
        obs_tick();
        check("idle_cyc", 32'(wb_cyc), 32'd0);
        check("idle_adr", wb_adr, 32'd3862);
        drive_tick();
        enable = 1'b1;
        obs_tick();
        check("resume_stb", 32'(wb_stb), 32'd1);
        check("resume_adr", wb_adr, 32'd3862);
        check("resume_dat", 32'(wb_dat_ms), 32'h0000);

        // Asynchronous reset in the middle of a burst.
        repeat (10) obs_tick();
        check("pre_rst_stb", 32'(wb_stb), 32'd1);
        drive_tick();
        rst_n = 1'b0;
        #1;
        check("arst_stb", 32'(wb_stb), 32'd0);
        check("arst_cyc", 32'(wb_cyc), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_fd", 32'(frame_done), 32'd0);
        check("arst_adr", wb_adr, 32'd0);
        drive_tick();
        drive_tick();
        rst_n = 1'b1;
        wait_px(0, 0, 20);
        check("post_rst_adr", wb_adr, 32'd0);
        check("post_rst_dat", 32'(wb_dat_ms), 32'hFFFF);
        repeat (5) obs_tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
